instruction_fetch: RTL and testbench

//   Fetch initiator for the byte-addressed, little-endian, combinational-read instruction memory.

---
 rtl/instruction_fetch_if.sv | 50 +++++
 rtl/instruction_fetch.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the instruction-memory fetch port and the decode-side handshake
//   of the instruction fetch unit.
//
//   Signals (directions seen from the fetch unit, modport master):
//     o_Addr         out 32  fetch byte address to instruction memory
//     i_Instruction  in  32  word returned combinationally for o_Addr
//     o_Instr        out 32  instruction at prefetch FIFO head (0 when empty)
//     o_Pc           out 32  PC of the head instruction (0 when empty)
//     o_Valid        out 1   head entry valid
//     i_Ready        in  1   decode accepts head this cycle
//     i_Redirect     in  1   flush and restart fetch at i_Redirect_Pc
//     i_Redirect_Pc  in  32  redirect target, bits [1:0] ignored
//
//   modport master : the fetch unit
//   modport slave  : memory + decode side
// -----------------------------------------------------------------------------
interface instruction_fetch_if;
    logic [31:0] o_Addr;
    logic [31:0] i_Instruction;
    logic [31:0] o_Instr;
    logic [31:0] o_Pc;
    logic        o_Valid;
    logic        i_Ready;
    logic        i_Redirect;
    logic [31:0] i_Redirect_Pc;

    modport master (
        output o_Addr,
        input  i_Instruction,
        output o_Instr,
        output o_Pc,
        output o_Valid,
        input  i_Ready,
        input  i_Redirect,
        input  i_Redirect_Pc
    );

    modport slave (
        input  o_Addr,
        output i_Instruction,
        input  o_Instr,
        input  o_Pc,
        input  o_Valid,
        output i_Ready,
        output i_Redirect,
        output i_Redirect_Pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch initiator for a byte-addressed, zero-latency instruction memory.
//   The fetch PC drives the memory address directly; every accepted word is
//   captured with its PC into a small prefetch FIFO whose head is offered to
//   decode with a valid/ready handshake. A redirect flushes the FIFO and
//   restarts fetch at the (word-aligned) target.
//
//   Parameters:
//     RESET_PC    first PC fetched after reset (bits [1:0] must be 0)
//     FIFO_DEPTH  prefetch entries, power of 2, >= 2
//
//   Ports:
//     i_Clk          in   clock, all state on the rising edge
//     i_Rst          in   synchronous active-high reset
//     bus            instruction_fetch_if.master (memory + decode signals)
//     o_Fetch_Count  out  32  pushes since reset          (IFETCH_PERF_EN only)
//     o_Stall_Count  out  32  cycles stalled on full FIFO  (IFETCH_PERF_EN only)
//
//   Configuration macro: IFETCH_PERF_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    instruction_fetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]         o_Fetch_Count,
    output logic [31:0]         o_Stall_Count
`endif
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Prefetch storage is data only; occupancy is tracked by count_q, so
    // these entries need no reset.
    logic [31:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q    [FIFO_DEPTH];

    logic valid;
    logic full;
    logic pop;
    logic push;

    // The two low target bits are dropped when forming the word address.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^bus.i_Redirect_Pc[1:0];

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);

    // Redirect squashes both the head handshake and the fetch this cycle.
    // A pop frees a slot on the same edge, so a full FIFO still accepts
    // a new word when the head is taken (no bubble at steady state).
    assign pop  = valid & bus.i_Ready & ~bus.i_Redirect;
    assign push = ~bus.i_Redirect & (~full | pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.i_Redirect) begin
            pc_d     = {bus.i_Redirect_Pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= bus.i_Instruction;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign bus.o_Addr  = pc_q;
    assign bus.o_Valid = valid;
    assign bus.o_Instr = valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign bus.o_Pc    = valid ? fifo_pc_q[rd_ptr_q]    : '0;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counters survive redirects; only reset clears them.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, push};
        stall_count_d = stall_count_q + {31'd0, full & ~pop & ~bus.i_Redirect};
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_Fetch_Count = fetch_count_q;
    assign o_Stall_Count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 2;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    always #5 i_Clk = ~i_Clk;

    instruction_fetch_if bus();
    instruction_fetch_if bus_w();

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    assign bus.i_Instruction   = rom(bus.o_Addr);
    assign bus_w.i_Instruction = rom(bus_w.o_Addr);
    assign bus_w.i_Ready       = 1'b1;
    assign bus_w.i_Redirect    = 1'b0;
    assign bus_w.i_Redirect_Pc = 32'd0;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt_w, stall_cnt_w;
`endif

    instruction_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .bus  (bus)
`ifdef IFETCH_PERF_EN
        ,
        .o_Fetch_Count(fetch_cnt),
        .o_Stall_Count(stall_cnt)
`endif
    );

    instruction_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
        .i_Clk(i_Clk),
        .i_Rst(i_Rst),
        .bus  (bus_w)
`ifdef IFETCH_PERF_EN
        ,
        .o_Fetch_Count(fetch_cnt_w),
        .o_Stall_Count(stall_cnt_w)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prefetch buffer as a queue of PCs plus the next fetch PC.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } cyc_t;

    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [31:0] m_fetch, m_stall;
    cyc_t        cyc_q[$];   // expected visible state, one per cycle
    logic [31:0] exp_q[$];   // expected accepted PCs, in order

    task automatic step(input logic rst, input logic ready, input logic redir,
                        input logic [31:0] rpc);
        cyc_t rec;
        @(posedge i_Clk);
        #1;
        i_Rst             = rst;
        bus.i_Ready       = ready;
        bus.i_Redirect    = redir;
        bus.i_Redirect_Pc = rpc;

        rec.valid = (m_q.size() != 0);
        rec.addr  = m_pc;
        rec.pc    = rec.valid ? m_q[0] : 32'd0;
        rec.fcnt  = m_fetch;
        rec.scnt  = m_stall;
        cyc_q.push_back(rec);

        if (rst) begin
            m_pc    = RESET_PC;
            m_q.delete();
            m_fetch = 0;
            m_stall = 0;
        end else if (redir) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (m_q.size() != 0 && ready) begin
                exp_q.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (m_q.size() < DEPTH) begin
                m_q.push_back(m_pc);
                m_pc    = m_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end else begin
                m_stall = m_stall + 32'd1;
            end
        end
    endtask

    // Monitor: per-cycle visible state and in-order accepted stream.
    initial begin
        cyc_t r;
        logic [31:0] e;
        forever begin
            @(negedge i_Clk);
            if (cyc_q.size() != 0) begin
                r = cyc_q.pop_front();
                chk("valid", {31'd0, bus.o_Valid}, {31'd0, r.valid});
                chk("addr",  bus.o_Addr,  r.addr);
                chk("pc",    bus.o_Pc,    r.pc);
                chk("instr", bus.o_Instr, r.valid ? rom(r.pc) : 32'd0);
`ifdef IFETCH_PERF_EN
                chk("fetch_count", fetch_cnt, r.fcnt);
                chk("stall_count", stall_cnt, r.scnt);
`endif
                if (bus.o_Valid && bus.i_Ready && !bus.i_Redirect && !i_Rst) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept actual pc=%h required none", bus.o_Pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("accept_pc",    bus.o_Pc,    e);
                        chk("accept_instr", bus.o_Instr, rom(e));
                    end
                end
            end
        end
    end

    // Second instance: wrap-around of a high reset PC.
    initial begin
        @(negedge i_Rst);
        @(negedge i_Clk);
        chk("w_reset_valid", {31'd0, bus_w.o_Valid}, 32'd0);
        chk("w_reset_addr",  bus_w.o_Addr, WRAP_PC);
        @(negedge i_Clk);
        chk("w_valid1", {31'd0, bus_w.o_Valid}, 32'd1);
        chk("w_pc1",    bus_w.o_Pc, 32'hFFFF_FFF8);
        @(negedge i_Clk);
        chk("w_pc2",    bus_w.o_Pc, 32'hFFFF_FFFC);
        @(negedge i_Clk);
        chk("w_pc3",    bus_w.o_Pc, 32'h0000_0000);
        chk("w_instr3", bus_w.o_Instr, 32'hA500_0000);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_Ready       = 1'b0;
        bus.i_Redirect    = 1'b0;
        bus.i_Redirect_Pc = 32'd0;
        m_pc    = RESET_PC;
        m_fetch = 0;
        m_stall = 0;
        repeat (3) @(posedge i_Clk);

        // streaming from reset
        repeat (10) step(1'b0, 1'b1, 1'b0, 32'd0);
        // decode stall, then drain
        repeat (5) step(1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);
        // full FIFO, single-cycle accept, then redirect while full
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
        repeat (4) step(1'b0, 1'b1, 1'b0, 32'd0);
        // address wrap via redirect near the top of memory
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF6);
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'd0);
        // reset with entries queued
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);
        // reset and redirect together
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);
        // random traffic
        repeat (400) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0, $urandom);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge i_Clk);
        #1;
        chk("accepts_outstanding", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
